// File: rtl/fp_div_mant_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_mant_seq_if
// Brief    : Operand/result handshake bundle for the fpDiv mantissa divider.
// Revision : 1.0
// ============================================================================
interface fp_div_mant_seq_if #(
    parameter int MANT_W = 24,
    parameter int QUOT_W = 27,
    parameter int TAG_W  = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] mant_a;
    logic [MANT_W-1:0] mant_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [QUOT_W-1:0] quot;
    logic              sticky;
    logic              dbz;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, mant_a, mant_b, in_tag, out_ready,
        input  in_ready, out_valid, quot, sticky, dbz, out_tag
    );

    modport slave (
        input  in_valid, mant_a, mant_b, in_tag, out_ready,
        output in_ready, out_valid, quot, sticky, dbz, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/fp_div_mant_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_mant_seq
// Brief    : Radix-2 restoring significand divider, one quotient bit per clock.
// Revision : 1.0
// ============================================================================
module fp_div_mant_seq #(
    parameter int MANT_W = 24,
    parameter int QUOT_W = 27,
    parameter int TAG_W  = 10
) (
    input  wire logic          aclk,
    input  wire logic          aresetn,
    fp_div_mant_seq_if.slave   bus
);
    localparam int REM_W = MANT_W + 2;
    localparam int CNT_W = $clog2(QUOT_W);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(QUOT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [MANT_W-1:0]  div_q, div_d;
    logic [QUOT_W-1:0]  quot_q, quot_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sticky_q, sticky_d;
    logic               dbz_q, dbz_d;
    logic [TAG_W-1:0]   tag_q, tag_d;

    logic [REM_W-1:0]   w_div_ext;
    logic               w_ge;
    logic [REM_W-1:0]   w_rem_new;

    // Restoring step: subtract only when the partial remainder covers the divisor.
    assign w_div_ext = {{(REM_W-MANT_W){1'b0}}, div_q};
    assign w_ge      = (rem_q >= w_div_ext);
    assign w_rem_new = w_ge ? (rem_q - w_div_ext) : rem_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            div_q    <= '0;
            quot_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            dbz_q    <= 1'b0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            quot_q   <= quot_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            dbz_q    <= dbz_d;
            tag_q    <= tag_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        div_d    = div_q;
        quot_d   = quot_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        dbz_d    = dbz_q;
        tag_d    = tag_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    div_d    = bus.mant_b;
                    tag_d    = bus.in_tag;
                    rem_d    = {{(REM_W-MANT_W){1'b0}}, bus.mant_a};
                    cnt_d    = C_CNT_LAST;
                    sticky_d = 1'b0;
                    if (bus.mant_b == '0) begin
                        quot_d  = '1;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        quot_d  = '0;
                        dbz_d   = 1'b0;
                        state_d = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                quot_d[cnt_q] = w_ge;
                if (cnt_q == '0) begin
                    rem_d    = w_rem_new;
                    sticky_d = (w_rem_new != '0);
                    state_d  = ST_DONE;
                end else begin
                    rem_d = {w_rem_new[REM_W-2:0], 1'b0};
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.quot      = quot_q;
    assign bus.sticky    = sticky_q;
    assign bus.dbz       = dbz_q;
    assign bus.out_tag   = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_mant_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_div_mant_seq
// Brief    : Self-checking bench for the sequential significand divider.
// Revision : 1.0
// ============================================================================
module tb_fp_div_mant_seq;
    localparam int MANT_W = 24;
    localparam int QUOT_W = 27;
    localparam int TAG_W  = 10;

    logic aclk;
    logic aresetn;
    int   checks;
    int   failures;

    fp_div_mant_seq_if #(.MANT_W(MANT_W), .QUOT_W(QUOT_W), .TAG_W(TAG_W)) bus ();

    fp_div_mant_seq #(.MANT_W(MANT_W), .QUOT_W(QUOT_W), .TAG_W(TAG_W)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Reference: quotient is floor(a * 2^(QUOT_W-1) / b), sticky is a non-zero remainder.
    function automatic logic [QUOT_W-1:0] ref_quot(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b);
        logic [63:0] n;
        n = 64'(a) << (QUOT_W - 1);
        return QUOT_W'(n / 64'(b));
    endfunction

    function automatic logic ref_sticky(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b);
        logic [63:0] n;
        n = 64'(a) << (QUOT_W - 1);
        return ((n % 64'(b)) != 64'd0);
    endfunction

    task automatic send(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b, input logic [TAG_W-1:0] t);
        @(negedge aclk);
        bus.in_valid = 1'b1;
        bus.mant_a   = a;
        bus.mant_b   = b;
        bus.in_tag   = t;
        @(posedge aclk);
        #1;
        bus.in_valid = 1'b0;
        bus.mant_a   = MANT_W'($urandom);
        bus.mant_b   = MANT_W'($urandom);
        bus.in_tag   = TAG_W'($urandom);
    endtask

    // Counts edges after the accept edge until out_valid; also notes any in_ready seen.
    task automatic wait_out(output int lat, output bit seen, output bit rdy_seen);
        lat      = 0;
        seen     = 1'b0;
        rdy_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            @(posedge aclk);
            #1;
            lat++;
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        @(posedge aclk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.quot !== '0) begin failures++; $display("FAIL reset_quot got=%h exp=0", bus.quot); end
        checks++; if ({bus.sticky, bus.dbz} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {bus.sticky, bus.dbz}); end
        checks++; if (bus.out_tag !== '0) begin failures++; $display("FAIL reset_tag got=%h exp=0", bus.out_tag); end
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_basic();
        int lat; bit seen; bit rdy;
        send(24'hC00000, 24'hC00000, 10'h155);
        wait_out(lat, seen, rdy);
        checks++; if (!seen || lat != QUOT_W) begin failures++; $display("FAIL basic_latency got=%0d seen=%b exp=%0d", lat, seen, QUOT_W); end
        checks++; if (bus.quot !== 27'h4000000) begin failures++; $display("FAIL basic_quot got=%h exp=4000000", bus.quot); end
        checks++; if ({bus.sticky, bus.dbz} !== 2'b00) begin failures++; $display("FAIL basic_flags got=%b exp=00", {bus.sticky, bus.dbz}); end
        checks++; if (bus.out_tag !== 10'h155) begin failures++; $display("FAIL basic_tag got=%h exp=155", bus.out_tag); end
        retire();
        send(24'hE00000, 24'hA00000, 10'h2AA);
        wait_out(lat, seen, rdy);
        checks++; if (bus.quot !== 27'h5999999) begin failures++; $display("FAIL frac_quot got=%h exp=5999999", bus.quot); end
        checks++; if (bus.sticky !== 1'b1) begin failures++; $display("FAIL frac_sticky got=%b exp=1", bus.sticky); end
        retire();
    endtask

    task automatic test_back_to_back();
        int lat; bit seen; bit rdy;
        send(24'hFFFFFF, 24'h800000, 10'h001);
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_after_accept got=%b exp=0", bus.in_ready); end
        wait_out(lat, seen, rdy);
        checks++; if (bus.quot !== 27'h7FFFFF8 || bus.sticky !== 1'b0) begin failures++; $display("FAIL b2b_max_quot got=%h/%b exp=7fffff8/0", bus.quot, bus.sticky); end
        checks++; if (rdy || bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_busy got=%b exp=0", rdy | bus.in_ready); end
        retire();
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_ready_after_retire got=%b/%b exp=1/0", bus.in_ready, bus.out_valid); end
        send(24'h800000, 24'hFFFFFF, 10'h002);
        wait_out(lat, seen, rdy);
        checks++; if (!seen || lat != QUOT_W) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, QUOT_W); end
        checks++; if (bus.quot !== 27'h2000002 || bus.sticky !== 1'b1) begin failures++; $display("FAIL b2b_min_quot got=%h/%b exp=2000002/1", bus.quot, bus.sticky); end
        retire();
    endtask

    task automatic test_backpressure();
        int lat; bit seen; bit rdy; bit bad;
        logic [QUOT_W-1:0] q0;
        bad = 1'b0;
        send(24'hD00000, 24'h900000, 10'h0F0);
        wait_out(lat, seen, rdy);
        q0 = ref_quot(24'hD00000, 24'h900000);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                bus.in_valid = 1'b1;
                bus.mant_a   = 24'h800000;
                bus.mant_b   = 24'hF00000;
                bus.in_tag   = 10'h3FF;
            end
            @(posedge aclk);
            #1;
            bus.in_valid = 1'b0;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quot !== q0 || bus.out_tag !== 10'h0F0 || bus.dbz !== 1'b0)
                bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL bp_hold quot=%h tag=%h valid=%b ready=%b exp=%h/0f0/1/0", bus.quot, bus.out_tag, bus.out_valid, bus.in_ready, q0); end
        retire();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_single_retire valid=%b ready=%b exp=0/1", bus.out_valid, bus.in_ready); end
        send(24'hA00000, 24'hC00000, 10'h0AB);
        wait_out(lat, seen, rdy);
        checks++; if (bus.quot !== ref_quot(24'hA00000, 24'hC00000) || bus.out_tag !== 10'h0AB) begin failures++; $display("FAIL bp_next_op got=%h/%h exp=%h/0ab", bus.quot, bus.out_tag, ref_quot(24'hA00000, 24'hC00000)); end
        retire();
    endtask

    task automatic test_dbz();
        int lat; bit seen; bit rdy;
        send(24'hC00000, 24'h000000, 10'h033);
        wait_out(lat, seen, rdy);
        checks++; if (!seen || lat != 1) begin failures++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
        checks++; if (bus.quot !== 27'h7FFFFFF || bus.dbz !== 1'b1 || bus.sticky !== 1'b0) begin failures++; $display("FAIL dbz_result got=%h/%b/%b exp=7ffffff/1/0", bus.quot, bus.dbz, bus.sticky); end
        checks++; if (bus.out_tag !== 10'h033) begin failures++; $display("FAIL dbz_tag got=%h exp=033", bus.out_tag); end
        retire();
    endtask

    task automatic test_reset_mid();
        int lat; bit seen; bit rdy;
        send(24'hE00000, 24'hA00000, 10'h1C3);
        repeat (12) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.quot !== '0 || bus.out_tag !== '0) begin failures++; $display("FAIL rst_mid_clear got=%b/%h/%h exp=0/0/0", bus.out_valid, bus.quot, bus.out_tag); end
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_ready got=%b/%b exp=1/0", bus.in_ready, bus.out_valid); end
        send(24'hC00000, 24'hC00000, 10'h011);
        wait_out(lat, seen, rdy);
        checks++; if (!seen || lat != QUOT_W || bus.quot !== 27'h4000000) begin failures++; $display("FAIL rst_mid_next got=%h lat=%0d exp=4000000 lat=%0d", bus.quot, lat, QUOT_W); end
        retire();
    endtask

    task automatic test_random();
        int lat; bit seen; bit rdy;
        logic [MANT_W-1:0] a, b;
        logic [TAG_W-1:0]  t;
        for (int n = 0; n < 40; n++) begin
            b = 24'h800000 | MANT_W'($urandom);
            if ($urandom_range(0, 3) == 0) a = MANT_W'($urandom) >> $urandom_range(0, 8);
            else                           a = 24'h800000 | MANT_W'($urandom);
            t = TAG_W'($urandom);
            send(a, b, t);
            wait_out(lat, seen, rdy);
            checks++;
            if (!seen || lat != QUOT_W || bus.quot !== ref_quot(a, b) || bus.sticky !== ref_sticky(a, b)
                || bus.dbz !== 1'b0 || bus.out_tag !== t) begin
                failures++;
                $display("FAIL rand_%0d a=%h b=%h got=%h/%b tag=%h lat=%0d exp=%h/%b tag=%h lat=%0d",
                         n, a, b, bus.quot, bus.sticky, bus.out_tag, lat, ref_quot(a, b), ref_sticky(a, b), t, QUOT_W);
            end
            retire();
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        aresetn       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.mant_a    = '0;
        bus.mant_b    = '0;
        bus.in_tag    = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_dbz();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
